write_queue: RTL

- Result buffer sitting directly upstream of the memory writer stage.
- Collects 32-bit result words from the execution core into a small FIFO.
- Drains the words one at a time to the writer, using that stage's start/ready handshake.
- Decouples bursty core output from the slower writer memory, which is multi-cycle and signals idle via ready.

---
 rtl/write_queue_pkg.sv | 15 +
 rtl/write_queue_if.sv | 27 ++
 rtl/write_queue_sync_fifo.sv | 72 +++++++
 rtl/write_queue.sv | 87 ++++++++
 4 files changed

// File: rtl/write_queue_pkg.sv
// Shared constants and drain FSM state type for the write queue
// that sits in front of the memory writer stage.
package write_queue_pkg;

    localparam int unsigned WQ_DATA_WIDTH    = 32;
    localparam int unsigned WQ_ADDR_BITS     = 3;
    localparam int unsigned WQ_SETTLE_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/write_queue_if.sv
// Core-side push handshake, writer-side start/ready handshake and queue status.
interface write_queue_if
    import write_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WQ_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = WQ_ADDR_BITS
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_start;
    logic                  out_ready;
    logic [ADDR_BITS:0]    count;
    logic                  empty;
    logic                  overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_data, out_start, count, empty, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_data, out_start, count, empty, overflow
    );
endinterface

// File: rtl/write_queue_sync_fifo.sv
// Storage FIFO for the write queue: pointers wrap naturally, full/empty come
// from the occupancy count, overflow is sticky until reset.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push_valid,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_BITS:0]    o_count,
    output logic                  o_overflow
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0]  r_wr_ptr;
    logic [ADDR_BITS-1:0]  r_rd_ptr;
    logic [ADDR_BITS:0]    r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign w_full  = r_count[ADDR_BITS];
    assign w_empty = (r_count == '0);
    assign w_push  = i_push_valid && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (i_push_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
endmodule

// File: rtl/write_queue.sv
// Result write queue: buffers core words and drains them one at a time to
// the multi-cycle memory writer using its start/ready handshake.
module write_queue
    import write_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = WQ_DATA_WIDTH,
    parameter int unsigned ADDR_BITS     = WQ_ADDR_BITS,
    parameter int unsigned SETTLE_CYCLES = WQ_SETTLE_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    write_queue_if.slave  bus
);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    drain_state_e          r_state;
    drain_state_e          w_state_nxt;
    logic [SW-1:0]         r_settle;
    logic [SW-1:0]         w_settle_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;
    logic                  r_out_start;
    logic                  w_out_start_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (bus.in_valid),
        .i_push_data  (bus.in_data),
        .i_pop        (w_pop),
        .o_rd_data    (w_rd_data),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (bus.count),
        .o_overflow   (bus.overflow)
    );

    assign w_pop = (r_state == ST_IDLE) && !w_empty && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_settle    <= '0;
            r_out_data  <= '0;
            r_out_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_settle    <= w_settle_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_start <= w_out_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_pop) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_settle == '0) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // writer ready is ignored while the settle counter runs down
    always_comb begin
        w_out_start_nxt = w_pop;
        w_out_data_nxt  = w_pop ? w_rd_data : r_out_data;
        w_settle_nxt    = r_settle;
        if (w_pop) begin
            w_settle_nxt = SW'(SETTLE_CYCLES - 1);
        end else if (r_state == ST_SETTLE && r_settle != '0) begin
            w_settle_nxt = r_settle - 1'b1;
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.empty     = w_empty;
    assign bus.out_data  = r_out_data;
    assign bus.out_start = r_out_start;
endmodule
